// File: rtl/dnn_sample_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dnn_feeder_pkg
// Purpose  : Shared types and default geometry for the DNN sample feeder.
// Revision : 1.0
// ============================================================================
package dnn_feeder_pkg;

  // Life cycle of one sample bank
  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  // Default geometry: 64 inputs in 16-activation beats, 6-clock blocks, 4 classes
  localparam int BEATS  = 4;
  localparam int CIDX_W = 3;
  localparam int LBL_W  = 2;

endpackage
`default_nettype wire

// File: rtl/dnn_sample_feeder_if.sv
`default_nettype none
// ============================================================================
// Interface : dnn_sample_feeder_if
// Purpose   : Host-side sample stream (one beat of activations per transfer,
//             label and eta carried alongside the first beat).
// Revision  : 1.0
// ============================================================================
interface dnn_sample_feeder_if #(
  parameter int width_in    = 8,
  parameter int ACT_PER_CLK = 16,
  parameter int LABEL_W     = 2,
  parameter int ETA_W       = 3
);
  logic                            s_valid;
  logic                            s_ready;
  logic [width_in*ACT_PER_CLK-1:0] s_data;
  logic [LABEL_W-1:0]              s_label;
  logic [ETA_W-1:0]                s_eta1pos;

  modport master (output s_valid, s_data, s_label, s_eta1pos, input s_ready);
  modport slave  (input s_valid, s_data, s_label, s_eta1pos, output s_ready);
endinterface
`default_nettype wire

// File: rtl/dnn_sample_feeder_bank.sv
`default_nettype none
// ============================================================================
// Module   : feeder_bank
// Purpose  : One sample bank: beat storage, label/eta registers, bank state,
//            in-order write port and a read port indexed by cycle_index.
// Revision : 1.0
// ============================================================================
module feeder_bank
  import dnn_feeder_pkg::*;
#(
  parameter int DW        = 128,
  parameter int NB        = BEATS,
  parameter int CW        = CIDX_W,
  parameter int LW        = LBL_W,
  parameter int ETA_W     = 3,
  parameter int N_OUT     = 4,
  parameter int Y_PER_CLK = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [CW-1:0]        wr_idx,
  input  logic                 wr_last,
  input  logic [DW-1:0]        wr_data,
  input  logic [LW-1:0]        wr_label,
  input  logic [ETA_W-1:0]     wr_eta,
  input  logic                 drain,
  input  logic                 retire,
  input  logic [CW-1:0]        rd_idx,
  output bank_state_t          state,
  output logic [DW-1:0]        rd_word,
  output logic [Y_PER_CLK-1:0] rd_y,
  output logic [ETA_W-1:0]     rd_eta
);

  logic [DW-1:0]    mem [NB];
  logic [LW-1:0]    label;
  logic [ETA_W-1:0] eta;

  // Beat storage needs no reset: the bank state decides whether it is valid
  always_ff @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (wr_en && (wr_idx == CW'(k))) mem[k] <= wr_data;
    end
  end

  // Bank state machine; label and eta are captured with the first beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      label <= '0;
      eta   <= '0;
    end else begin
      if (wr_en && (wr_idx == '0)) begin
        label <= wr_label;
        eta   <= wr_eta;
      end
      case (state)
        EMPTY:    if (wr_en) state <= wr_last ? FULL : FILLING;
        FILLING:  if (wr_en && wr_last) state <= FULL;
        FULL:     if (drain) state <= DRAINING;
        DRAINING: if (retire) state <= EMPTY;
        default:  state <= EMPTY;
      endcase
    end
  end

  // Read port: word c for c < NB, zero for the trailing clocks of a block
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NB; k++) begin
      if (rd_idx == CW'(k)) rd_word = mem[k];
    end
  end

  // One-hot ideal-output chunk for the current clock of the block
  always_comb begin
    rd_y = '0;
    for (int j = 0; j < Y_PER_CLK; j++) begin
      if (((int'(rd_idx) * Y_PER_CLK + j) < N_OUT) &&
          (int'(label) == (int'(rd_idx) * Y_PER_CLK + j)))
        rd_y[j] = 1'b1;
    end
  end

  assign rd_eta = eta;

endmodule
`default_nettype wire

// File: rtl/dnn_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module   : dnn_sample_feeder
// Purpose  : Double-buffered sample feeder aligned to the network block cycle.
//            Optional macro FEEDER_UNDERRUN_CNT_EN adds a saturating 16-bit
//            underrun_cnt output.
// Revision : 1.0
// ============================================================================
module dnn_sample_feeder
  import dnn_feeder_pkg::*;
#(
  parameter int width_in    = 8,
  parameter int ACT_PER_CLK = 16,
  parameter int N_IN        = 64,
  parameter int N_OUT       = 4,
  parameter int Y_PER_CLK   = 1,
  parameter int CPC         = 6,
  parameter int ETA_W       = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [$clog2(CPC)-1:0]          cycle_index,
  dnn_sample_feeder_if.slave              host,
  output logic [width_in*ACT_PER_CLK-1:0] a_in,
  output logic [Y_PER_CLK-1:0]            y_in,
  output logic [ETA_W-1:0]                eta1pos_in,
  output logic                            sample_active,
  output logic                            underrun
`ifdef FEEDER_UNDERRUN_CNT_EN
  ,output logic [15:0]                    underrun_cnt
`endif
);

  localparam int NB = N_IN / ACT_PER_CLK;
  localparam int CW = $clog2(CPC);
  localparam int LW = $clog2(N_OUT);
  localparam int DW = width_in * ACT_PER_CLK;

  bank_state_t            st      [2];
  logic [DW-1:0]          word    [2];
  logic [Y_PER_CLK-1:0]   ybits   [2];
  logic [ETA_W-1:0]       eta     [2];

  logic [CW-1:0] beat_cnt;
  logic          fill_ptr;   // bank receiving host beats
  logic          next_ptr;   // oldest bank not yet presented
  logic          accept;
  logic          wr_last;
  logic          swap;
  logic          present;
  logic          sel;

  // Banks fill and drain in strict alternation, so next_ptr always names the
  // oldest complete sample and the draining bank is the one before it.
  assign host.s_ready = (st[fill_ptr] == EMPTY) || (st[fill_ptr] == FILLING);
  assign accept       = host.s_valid && host.s_ready;
  assign wr_last      = (beat_cnt == CW'(NB - 1));
  assign swap         = (cycle_index == CW'(CPC - 1));
  assign present      = swap && (st[next_ptr] == FULL);
  assign sel          = ~next_ptr;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    feeder_bank #(
      .DW        (DW),
      .NB        (NB),
      .CW        (CW),
      .LW        (LW),
      .ETA_W     (ETA_W),
      .N_OUT     (N_OUT),
      .Y_PER_CLK (Y_PER_CLK)
    ) u_bank (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (accept && (fill_ptr == 1'(b))),
      .wr_idx   (beat_cnt),
      .wr_last  (wr_last),
      .wr_data  (host.s_data),
      .wr_label (host.s_label),
      .wr_eta   (host.s_eta1pos),
      .drain    (present && (next_ptr == 1'(b))),
      .retire   (swap && (st[b] == DRAINING)),
      .rd_idx   (cycle_index),
      .state    (st[b]),
      .rd_word  (word[b]),
      .rd_y     (ybits[b]),
      .rd_eta   (eta[b])
    );
  end

  // Fill pointer / beat counter, block-boundary swap and status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt      <= '0;
      fill_ptr      <= 1'b0;
      next_ptr      <= 1'b0;
      sample_active <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      if (accept) begin
        if (wr_last) begin
          beat_cnt <= '0;
          fill_ptr <= ~fill_ptr;
        end else begin
          beat_cnt <= beat_cnt + CW'(1);
        end
      end
      underrun <= 1'b0;
      if (swap) begin
        if (present) begin
          sample_active <= 1'b1;
          next_ptr      <= ~next_ptr;
        end else begin
          sample_active <= 1'b0;
          underrun      <= 1'b1;
        end
      end
    end
  end

  // Network-side outputs come from the draining bank, zero when idle
  always_comb begin
    a_in       = '0;
    y_in       = '0;
    eta1pos_in = '0;
    if (sample_active) begin
      a_in       = word[sel];
      y_in       = ybits[sel];
      eta1pos_in = eta[sel];
    end
  end

`ifdef FEEDER_UNDERRUN_CNT_EN
  // Saturating count of starved block boundaries
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun_cnt <= '0;
    end else if (swap && !present && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dnn_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dnn_sample_feeder
// Purpose  : Scoreboard bench for dnn_sample_feeder. A queue-based sample model
//            predicts each block; a monitor compares every clock.
// Revision : 1.0
// ============================================================================
module tb_dnn_sample_feeder;

  localparam int W     = 8;
  localparam int APC   = 16;
  localparam int NIN   = 64;
  localparam int NOUT  = 4;
  localparam int YPC   = 1;
  localparam int CPC   = 6;
  localparam int ETA_W = 3;
  localparam int NB    = NIN / APC;
  localparam int DW    = W * APC;
  localparam int CW    = $clog2(CPC);
  localparam int LW    = $clog2(NOUT);

  typedef struct packed {
    logic                act;
    logic                und;
    logic [NB*DW-1:0]    words;
    logic [LW-1:0]       lbl;
    logic [ETA_W-1:0]    eta;
  } blk_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [CW-1:0]   cycle_index = '0;
  logic [DW-1:0]   a_in;
  logic [YPC-1:0]  y_in;
  logic [ETA_W-1:0] eta1pos_in;
  logic            sample_active;
  logic            underrun;
`ifdef FEEDER_UNDERRUN_CNT_EN
  logic [15:0]     underrun_cnt;
`endif

  dnn_sample_feeder_if #(.width_in(W), .ACT_PER_CLK(APC), .LABEL_W(LW), .ETA_W(ETA_W)) host ();

  dnn_sample_feeder #(
    .width_in(W), .ACT_PER_CLK(APC), .N_IN(NIN), .N_OUT(NOUT),
    .Y_PER_CLK(YPC), .CPC(CPC), .ETA_W(ETA_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cycle_index   (cycle_index),
    .host          (host.slave),
    .a_in          (a_in),
    .y_in          (y_in),
    .eta1pos_in    (eta1pos_in),
    .sample_active (sample_active),
    .underrun      (underrun)
`ifdef FEEDER_UNDERRUN_CNT_EN
    ,.underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: complete samples wait in pend_q; each block boundary
  // takes the oldest one (or starves) and queues the expected block.
  blk_t             exp_q[$];
  blk_t             pend_q[$];
  bit               presenting;
  logic [NB*DW-1:0] part_words;
  logic [LW-1:0]    part_lbl;
  logic [ETA_W-1:0] part_eta;
  int               part_n;
  int               cidx;
  int               und_total;

  function automatic void chk(string name, logic [DW-1:0] got, logic [DW-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s at t=%0t: got %0h want %0h", name, $time, got, want);
    end
  endfunction

  function automatic bit m_ready();
    return (pend_q.size() + int'(presenting)) < 2;
  endfunction

  function automatic void model_edge(bit acc, int c, logic [DW-1:0] d,
                                     logic [LW-1:0] l, logic [ETA_W-1:0] e);
    blk_t b;
    b = '0;
    if (c == CPC - 1) begin
      if (pend_q.size() > 0) begin
        b = pend_q.pop_front();
        b.act = 1'b1;
        presenting = 1'b1;
      end else begin
        b.und = 1'b1;
        presenting = 1'b0;
        und_total++;
      end
      exp_q.push_back(b);
    end
    if (acc) begin
      if (part_n == 0) begin
        part_lbl = l;
        part_eta = e;
      end
      part_words[part_n*DW +: DW] = d;
      part_n++;
      if (part_n == NB) begin
        b = '0;
        b.words = part_words;
        b.lbl   = part_lbl;
        b.eta   = part_eta;
        pend_q.push_back(b);
        part_n = 0;
      end
    end
  endfunction

  // One clock: drive at negedge, check s_ready, update model at posedge
  task automatic step(input bit v, input logic [DW-1:0] d, input logic [LW-1:0] l,
                      input logic [ETA_W-1:0] e, output bit acc);
    bit r;
    host.s_valid   = v;
    host.s_data    = v ? d : {4{$urandom}};
    host.s_label   = l;
    host.s_eta1pos = e;
    #1;
    r = m_ready();
    chk("s_ready", DW'(host.s_ready), DW'(r));
    acc = v && r;
    @(posedge clk);
    model_edge(acc, cidx, d, l, e);
    @(negedge clk);
    cidx = (cidx + 1) % CPC;
    cycle_index = CW'(cidx);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, acc);
  endtask

  task automatic send(input logic [NB*DW-1:0] w, input logic [LW-1:0] l,
                      input logic [ETA_W-1:0] e, input int gap_pct);
    int  k;
    bit  acc;
    bit  v;
    k = 0;
    while (k < NB) begin
      v = ($urandom_range(99) >= gap_pct);
      step(v, w[k*DW +: DW], l, e, acc);
      if (acc) k++;
    end
  endtask

  function automatic logic [NB*DW-1:0] rand_words();
    logic [NB*DW-1:0] w;
    for (int i = 0; i < NB * DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Asynchronous reset: outputs must clear at once; model restarts empty
  task automatic do_reset();
    blk_t b;
    reset = 1'b1;
    host.s_valid = 1'b0;
    #1;
    chk("rst_a_in", a_in, '0);
    chk("rst_y_in", DW'(y_in), '0);
    chk("rst_eta", DW'(eta1pos_in), '0);
    chk("rst_active", DW'(sample_active), '0);
    chk("rst_underrun", DW'(underrun), '0);
    chk("rst_s_ready", DW'(host.s_ready), DW'(1));
    exp_q.delete();
    pend_q.delete();
    presenting = 1'b0;
    part_n     = 0;
    part_words = '0;
    und_total  = 0;
    b = '0;
    exp_q.push_back(b);
    @(negedge clk);
    @(negedge clk);
    cidx = 0;
    cycle_index = '0;
    reset = 1'b0;
  endtask

  // Monitor: take a new expected block at c == 0 and compare every clock
  initial begin : monitor
    blk_t             cur;
    logic [NB*DW-1:0] ws;
    logic [DW-1:0]    ea;
    logic [YPC-1:0]   ey;
    int               c;
    cur = '0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) continue;
      c = int'(cycle_index);
      if (c == 0) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL block_queue at t=%0t: got empty want a predicted block", $time);
          cur = '0;
        end else begin
          cur = exp_q.pop_front();
        end
      end
      ea = '0;
      ey = '0;
      if (cur.act) begin
        ws = cur.words;
        if (c < NB) ea = ws[c*DW +: DW];
        for (int j = 0; j < YPC; j++)
          if ((c * YPC + j) < NOUT && int'(cur.lbl) == (c * YPC + j)) ey[j] = 1'b1;
      end
      chk("a_in", a_in, ea);
      chk("y_in", DW'(y_in), DW'(ey));
      chk("eta1pos_in", DW'(eta1pos_in), cur.act ? DW'(cur.eta) : '0);
      chk("sample_active", DW'(sample_active), DW'(cur.act));
      chk("underrun", DW'(underrun), DW'((c == 0) && cur.und));
    end
  end

  initial begin : driver
    logic [NB*DW-1:0] w;
    bit               acc;
    host.s_valid = 1'b0;
    host.s_data = '0;
    host.s_label = '0;
    host.s_eta1pos = '0;
    cidx = 0;
    @(negedge clk);
    do_reset();

    // Idle after reset: three starved blocks
    idle(3 * CPC);

    // Directed sample: word k = {16{k+1}}, label 2, eta 3
    for (int k = 0; k < NB; k++) w[k*DW +: DW] = {APC{8'(k + 1)}};
    send(w, 2'd2, 3'd3, 0);
    idle(2 * CPC);

    // Three samples back to back
    for (int s = 0; s < 3; s++) send(rand_words(), LW'($urandom), ETA_W'($urandom), 0);
    idle(3 * CPC);

    // Final beat lands on the swap edge
    while (cidx != 2) idle(1);
    send(rand_words(), LW'($urandom), ETA_W'($urandom), 0);
    idle(3 * CPC);

    // Reset at beat 2 of a fill while a sample is draining
    while (cidx != 0) idle(1);
    send(rand_words(), 2'd1, 3'd5, 0);
    while (cidx != 0) idle(1);
    w = rand_words();
    step(1'b1, w[0 +: DW], 2'd3, 3'd6, acc);
    step(1'b1, w[DW +: DW], 2'd3, 3'd6, acc);
    do_reset();
    send(rand_words(), LW'($urandom), ETA_W'($urandom), 0);
    idle(2 * CPC);

    // Randomized traffic with gaps
    for (int s = 0; s < 25; s++) begin
      send(rand_words(), LW'($urandom), ETA_W'($urandom), $urandom_range(60));
      if ($urandom_range(3) == 0) idle($urandom_range(8));
    end
    idle(3 * CPC);

`ifdef FEEDER_UNDERRUN_CNT_EN
    chk("underrun_cnt", DW'(underrun_cnt), DW'(und_total > 65535 ? 65535 : und_total));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
